// File: rtl/btb_update_ctrl_if.sv
// ============================================================================
// Module   : btb_update_ctrl_if
// Brief    : Mispredict update requests in, branch-target cache write port out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btb_update_ctrl_if #(
  parameter int PC_W  = 13,
  parameter int IDX_W = 11,
  parameter int TAG_W = 2
);
  logic                   fail_predictD;
  logic [PC_W-1:0]        pcD;
  logic [PC_W-1:0]        nextpcD;
  logic                   fail_predictE;
  logic [PC_W-1:0]        pcE;
  logic [PC_W-1:0]        nextpcE;
  logic                   flush_req;
  logic [IDX_W-1:0]       w_addr;
  logic [TAG_W+PC_W:0]    w_data;
  logic                   wen;
  logic                   pred_en;
  logic                   busy;
  logic                   drop_pulse;

  modport master (
    output fail_predictD, pcD, nextpcD, fail_predictE, pcE, nextpcE, flush_req,
    input  w_addr, w_data, wen, pred_en, busy, drop_pulse
  );

  modport slave (
    input  fail_predictD, pcD, nextpcD, fail_predictE, pcE, nextpcE, flush_req,
    output w_addr, w_data, wen, pred_en, busy, drop_pulse
  );
endinterface

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
// ============================================================================
// Module   : btb_update_ctrl
// Brief    : Sweeps the branch-target cache invalid after reset/flush and merges
//            D/E mispredict updates into its single write port via a small FIFO.
//            Optional counters: define BTB_UPD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_update_ctrl #(
  parameter int PC_W       = 13,
  parameter int IDX_W      = 11,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic           CLK,
  input  wire logic           RST_N,
  btb_update_ctrl_if.slave    bus
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [31:0]         stat_upd,
  output logic [31:0]         stat_drop,
  output logic [31:0]         stat_dsquash
`endif
);

  localparam int               c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int               c_cnt_w   = c_ptr_w + 1;
  localparam int               c_data_w  = 1 + TAG_W + PC_W;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [IDX_W-1:0] c_last    = {IDX_W{1'b1}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [IDX_W-1:0]       r_cnt;
  logic                   r_wen;
  logic [IDX_W-1:0]       r_addr;
  logic [c_data_w-1:0]    r_data;
  logic                   r_busy;
  logic                   r_pred_en;
  logic                   r_drop;

  // FIFO entries hold {pc, nextpc}; index/tag are split out on write.
  logic [2*PC_W-1:0]      r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_cnt_w-1:0]     r_count;

  logic                   w_cand_vld;
  logic [PC_W-1:0]        w_cand_pc;
  logic [PC_W-1:0]        w_cand_tgt;
  logic [PC_W-1:0]        w_head_pc;
  logic [PC_W-1:0]        w_head_tgt;
  logic                   w_in_clear;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bypass;
  logic                   w_drop;
  logic [c_ptr_w-1:0]     w_wr_idx;

  // E wins: a D request in the same cycle sits on the squashed path.
  always_comb begin
    w_cand_vld = bus.fail_predictE | bus.fail_predictD;
    w_cand_pc  = bus.fail_predictE ? bus.pcE     : bus.pcD;
    w_cand_tgt = bus.fail_predictE ? bus.nextpcE : bus.nextpcD;
    {w_head_pc, w_head_tgt} = r_mem[r_rd_ptr];
    w_in_clear = (r_state == S_CLEAR);
    w_empty    = (r_count == '0);
    w_full     = (r_count == c_depth);
    w_pop      = !bus.flush_req && !w_in_clear && !w_empty;
    w_bypass   = !bus.flush_req && !w_in_clear && w_empty && w_cand_vld;
    w_drop     = !bus.flush_req && w_in_clear && w_full && w_cand_vld;
    w_push     = w_cand_vld && (bus.flush_req ||
                                (w_in_clear && !w_full) ||
                                (!w_in_clear && !w_empty));
    w_wr_idx   = bus.flush_req ? '0 : r_wr_ptr;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_req) begin
      w_state_nxt = S_CLEAR;
    end else if (r_state == S_CLEAR && r_cnt == c_last) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= {w_cand_pc, w_cand_tgt};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b1;
      r_pred_en <= 1'b0;
      r_drop    <= 1'b0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_drop    <= w_drop;
      r_busy    <= bus.flush_req | w_in_clear;
      r_pred_en <= !(bus.flush_req | w_in_clear);

      if (bus.flush_req) begin
        r_wen <= 1'b0;
        r_cnt <= '0;
      end else if (w_in_clear) begin
        r_wen  <= 1'b1;
        r_addr <= r_cnt;
        r_data <= '0;
        r_cnt  <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_wen  <= 1'b1;
        r_addr <= w_head_pc[IDX_W-1:0];
        r_data <= {1'b1, w_head_pc[PC_W-1:IDX_W], w_head_tgt};
      end else if (w_bypass) begin
        r_wen  <= 1'b1;
        r_addr <= w_cand_pc[IDX_W-1:0];
        r_data <= {1'b1, w_cand_pc[PC_W-1:IDX_W], w_cand_tgt};
      end else begin
        r_wen  <= 1'b0;
      end

      if (bus.flush_req) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= w_push ? c_ptr_one : '0;
        r_count  <= w_push ? c_cnt_w'(1) : '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef BTB_UPD_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_upd     <= '0;
      stat_drop    <= '0;
      stat_dsquash <= '0;
    end else begin
      if (w_cand_vld && !w_drop)                  stat_upd     <= stat_upd + 32'd1;
      if (w_drop)                                 stat_drop    <= stat_drop + 32'd1;
      if (bus.fail_predictE && bus.fail_predictD) stat_dsquash <= stat_dsquash + 32'd1;
    end
  end
`endif

  assign bus.wen        = r_wen;
  assign bus.w_addr     = r_addr;
  assign bus.w_data     = r_data;
  assign bus.busy       = r_busy;
  assign bus.pred_en    = r_pred_en;
  assign bus.drop_pulse = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
// ============================================================================
// Module   : tb_btb_update_ctrl
// Brief    : Directed self-checking bench for btb_update_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_update_ctrl;
  localparam int PC_W       = 13;
  localparam int IDX_W      = 11;
  localparam int TAG_W      = 2;
  localparam int FIFO_DEPTH = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   row_bad  = 0;

  btb_update_ctrl_if #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_upd, stat_drop, stat_dsquash;
`endif

  btb_update_ctrl #(
    .PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
`ifdef BTB_UPD_STATS_EN
    ,
    .stat_upd     (stat_upd),
    .stat_drop    (stat_drop),
    .stat_dsquash (stat_dsquash)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.fail_predictD = 1'b0;
    bus.fail_predictE = 1'b0;
    bus.flush_req     = 1'b0;
  endtask

  task automatic req_d(input logic [12:0] pc, input logic [12:0] tgt);
    bus.fail_predictD = 1'b1;
    bus.pcD           = pc;
    bus.nextpcD       = tgt;
  endtask

  // One sweep cycle: invalidating write of idx, busy, predictions disabled.
  task automatic row(input int idx, input logic exp_drop);
    tick();
    if (bus.wen !== 1'b1 || 32'(bus.w_addr) !== 32'(idx) || bus.w_data !== 16'h0000 ||
        bus.busy !== 1'b1 || bus.pred_en !== 1'b0 || bus.drop_pulse !== exp_drop) begin
      row_bad++;
    end
  endtask

  task automatic sweep(input int first, input int last);
    for (int i = first; i <= last; i++) row(i, 1'b0);
  endtask

  task automatic sweep_done(input string tag);
    check(tag, 32'(row_bad), 32'd0);
    row_bad = 0;
  endtask

  task automatic check_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, ".wen"},  32'(bus.wen), 32'd1);
    check({tag, ".addr"}, 32'(bus.w_addr), addr);
    check({tag, ".data"}, 32'(bus.w_data), data);
  endtask

  initial begin
    clr();
    bus.pcD = '0; bus.nextpcD = '0; bus.pcE = '0; bus.nextpcE = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.wen",     32'(bus.wen), 32'd0);
    check("rst.addr",    32'(bus.w_addr), 32'd0);
    check("rst.data",    32'(bus.w_data), 32'd0);
    check("rst.pred_en", 32'(bus.pred_en), 32'd0);
    check("rst.busy",    32'(bus.busy), 32'd1);
    check("rst.drop",    32'(bus.drop_pulse), 32'd0);

    // Power-up sweep
    RST_N = 1'b1;
    sweep(0, 2047);
    sweep_done("sweep_reset");
    tick();
    check("idle.wen",     32'(bus.wen), 32'd0);
    check("idle.busy",    32'(bus.busy), 32'd0);
    check("idle.pred_en", 32'(bus.pred_en), 32'd1);

    // D update bypasses straight to the write port
    req_d(13'h0123, 13'h0456);
    tick(); clr();
    check_wr("upd_d", 32'h123, 32'h8456);
    tick();
    check("upd_d.after", 32'(bus.wen), 32'd0);

    // E and D together: only E is written
    bus.fail_predictE = 1'b1; bus.pcE = 13'h1805; bus.nextpcE = 13'h0010;
    req_d(13'h0004, 13'h0777);
    tick(); clr();
    check_wr("upd_e", 32'h005, 32'hE010);
    tick();
    check("upd_e.single", 32'(bus.wen), 32'd0);

    // Back-to-back bypass writes to the same index, in order
    req_d(13'h0010, 13'h0001);
    tick();
    req_d(13'h0010, 13'h0002);
    check_wr("b2b0", 32'h010, 32'h8001);
    tick(); clr();
    check_wr("b2b1", 32'h010, 32'h8002);

    // Flush from IDLE, five updates during the sweep: four buffered, one dropped
    bus.flush_req = 1'b1;
    tick(); clr();
    check("flush.wen",     32'(bus.wen), 32'd0);
    check("flush.busy",    32'(bus.busy), 32'd1);
    check("flush.pred_en", 32'(bus.pred_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      req_d(13'(13'h0100 + k), 13'(13'h0A00 + k));
      row(k, (k == 4) ? 1'b1 : 1'b0);
    end
    clr();
    check("drop_5th", 32'(bus.drop_pulse), 32'd1);
    sweep(5, 2047);
    sweep_done("sweep_flush");
    for (int k = 0; k < 4; k++) begin
      tick();
      check_wr("drain", 32'h100 + 32'(k), 32'h8A00 + 32'(k));
    end
    tick();
    check("drain.end", 32'(bus.wen), 32'd0);

    // Queue two updates mid-sweep, then flush with a fresh candidate
    bus.flush_req = 1'b1;
    tick(); clr();
    req_d(13'h0200, 13'h0055);
    row(0, 1'b0);
    req_d(13'h0201, 13'h0066);
    row(1, 1'b0);
    clr();
    sweep(2, 9);
    bus.flush_req = 1'b1;
    req_d(13'h0300, 13'h0033);
    tick(); clr();
    check("flush2.wen",     32'(bus.wen), 32'd0);
    check("flush2.busy",    32'(bus.busy), 32'd1);
    check("flush2.pred_en", 32'(bus.pred_en), 32'd0);
    sweep(0, 2047);
    sweep_done("sweep_restart");
    tick();
    check_wr("flush_keep", 32'h300, 32'h8033);
    tick();
    check("queued_gone", 32'(bus.wen), 32'd0);
`ifdef BTB_UPD_STATS_EN
    check("stat_upd",     stat_upd, 32'd11);
    check("stat_drop",    stat_drop, 32'd1);
    check("stat_dsquash", stat_dsquash, 32'd1);
`endif

    // Asynchronous reset at sweep index 1000 with three entries buffered
    bus.flush_req = 1'b1;
    tick(); clr();
    for (int k = 0; k < 3; k++) begin
      req_d(13'(13'h0400 + k), 13'(13'h0100 + k));
      row(k, 1'b0);
    end
    clr();
    sweep(3, 1000);
    sweep_done("sweep_pre_rst");
    RST_N = 1'b0;
    #2;
    check("arst.wen",     32'(bus.wen), 32'd0);
    check("arst.addr",    32'(bus.w_addr), 32'd0);
    check("arst.data",    32'(bus.w_data), 32'd0);
    check("arst.busy",    32'(bus.busy), 32'd1);
    check("arst.pred_en", 32'(bus.pred_en), 32'd0);
`ifdef BTB_UPD_STATS_EN
    check("arst.stat_upd", stat_upd, 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    sweep(0, 2047);
    sweep_done("sweep_after_rst");
    tick();
    check("no_stale.wen",  32'(bus.wen), 32'd0);
    check("no_stale.busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Sequences all writes into the direct-mapped branch-target cache: 2048 entries, each 1b valid + 2b tag + 13b target.
- After reset, and on a software flush, it sweeps every entry to invalid.
- It merges mispredict updates from the D and E stages into the cache's single write port, buffering them in a small FIFO while the sweep owns the port.
- Sits between the D/E mispredict logic and the cache write port; its enable output gates prediction-hit use in F.

Parameters:
- PC_W, 13, word PC width (byte PC[14:2]).
- IDX_W, 11, cache index width (PC[IDX_W-1:0]).
- TAG_W, 2, tag width (PC[PC_W-1:IDX_W]); PC_W = IDX_W + TAG_W is required.
- FIFO_DEPTH, 4, pending-update buffer entries (power of two, ≥2).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- fail_predictD  in  1  D-stage mispredict, update request.
- pcD  in  PC_W  PC of the D-stage branch.
- nextpcD  in  PC_W  resolved target from D.
- fail_predictE  in  1  E-stage mispredict, update request.
- pcE  in  PC_W  PC of the E-stage branch.
- nextpcE  in  PC_W  resolved target from E.
- flush_req  in  1  single-cycle pulse: invalidate whole cache.
- w_addr  out  IDX_W  cache write index (registered).
- w_data  out  1+TAG_W+PC_W  {valid, tag, target} (registered).
- wen  out  1  cache write enable (registered).
- pred_en  out  1  1 = cache contents trustworthy; F may use hits.
- busy  out  1  sweep in progress.
- drop_pulse  out  1  one cycle high when an update was discarded (FIFO full).

Behaviour:
- Reset (RST_N low, asynchronous):
  - Outputs: wen=0, w_addr=0, w_data=0, pred_en=0, busy=1, drop_pulse=0.
  - Internal: FIFO empty, sweep counter=0, state=CLEAR.
- States:
  - CLEAR: each cycle registers wen=1, w_addr=cnt, w_data=0; cnt increments from 0 to 2^IDX_W-1.
  - The cycle after writing the last index: state=IDLE, busy=0, pred_en=1.
  - A full sweep is exactly 2^IDX_W wen cycles (2048 by default), ascending, with no gaps.
- Update selection (every cycle, any state):
  - If fail_predictE=1: candidate = {pcE, nextpcE}. fail_predictD is ignored that cycle because the D instruction is on the squashed path.
  - Else if fail_predictD=1: candidate = {pcD, nextpcD}.
  - Candidate entry = {1'b1, pc[PC_W-1:IDX_W], nextpc}, written at index pc[IDX_W-1:0].
- In CLEAR: the candidate is pushed into the FIFO. If the FIFO is full, the candidate is dropped and drop_pulse=1 the next cycle.
- In IDLE:
  - FIFO non-empty: pop the head to the write registers (wen=1 next cycle); the candidate is pushed the same cycle, preserving order.
  - FIFO empty: the candidate bypasses the FIFO straight to the write registers, so wen=1 exactly one cycle after the request.
  - Nothing pending: wen=0.
- Throughput: in IDLE, one write per cycle; a push and a pop in the same cycle on a full FIFO is legal (no drop).
- flush_req:
  - From any state: the FIFO is emptied (pending updates discarded), cnt=0, state=CLEAR, busy=1, pred_en=0 from the next cycle.
  - A candidate arriving in the same cycle as flush_req is kept and pushed into the emptied FIFO.
  - flush_req during CLEAR restarts the sweep at index 0.
- Same-index updates are written in arrival order; the last write wins.
- Reset asserted mid-sweep or mid-drain aborts immediately and returns to the reset values.

Optional Feature:
- BTB_UPD_STATS_EN:
  - Defined: adds outputs stat_upd[31:0] (accepted candidates), stat_drop[31:0] (drops) and stat_dsquash[31:0] (D requests ignored because E fired the same cycle). All reset to 0 on RST_N, wrap modulo 2^32, and are unaffected by flush_req.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release RST_N at cycle 0 -> wen high for exactly 2048 consecutive cycles, w_addr 0..2047, w_data=0; then busy=0, pred_en=1, wen=0.
- In IDLE, fail_predictD=1, pcD=0x0123, nextpcD=0x0456 -> next cycle wen=1, w_addr=0x123, w_data=0x8456.
- Same cycle: fail_predictE=1 (pcE=0x1805, nextpcE=0x0010) and fail_predictD=1 (pcD=0x0004) -> a single write, w_addr=0x005, w_data=0xE010; no write to index 4.
- During the sweep, issue 5 D updates -> first 4 written in order immediately after index 2047, drop_pulse once for the 5th.
- Queue 2 updates during the sweep, then pulse flush_req -> sweep restarts at 0, queued updates never written, pred_en=0 until 2048 cycles later.
- Assert RST_N low at sweep index 1000 with the FIFO holding 3 entries -> outputs return to reset values asynchronously; after release, the sweep starts at 0 and no stale update is written.
